// File: rtl/axi_stream_channel_sched_pkg.sv
// Shared stream-type codes and scheduler state encoding for the AXI-over-Ethernet stream path.
// Used by the converters, this scheduler and the packetiser.
package ethhelper_stream_pkg;

  localparam int CH_AW = 0;
  localparam int CH_W  = 1;
  localparam int CH_B  = 2;
  localparam int CH_AR = 3;
  localparam int CH_R  = 4;

  localparam int STREAM_TYPE_WIDTH = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sched_state_t;

endpackage

// File: rtl/axi_stream_channel_sched_if.sv
// Converter-bank side and output-stream side signals of the channel scheduler.
// The master modport is the scheduler itself; slave is the surrounding converters and packetiser.
interface axi_stream_channel_sched_if #(
  parameter int NUM_CH            = 5,
  parameter int DATA_WIDTH        = 128,
  parameter int STREAM_TYPE_WIDTH = 3
);

  logic [NUM_CH-1:0]            ch_req;
  logic [NUM_CH-1:0]            ch_valid;
  logic [NUM_CH*DATA_WIDTH-1:0] ch_data;
  logic [NUM_CH-1:0]            ch_last;
  logic [NUM_CH-1:0]            can_forward;
  logic                         m_tvalid;
  logic [DATA_WIDTH-1:0]        m_tdata;
  logic [STREAM_TYPE_WIDTH-1:0] m_tuser;
  logic                         m_tlast;
  logic                         m_tready;

  modport master (
    input  ch_req, ch_valid, ch_data, ch_last, m_tready,
    output can_forward, m_tvalid, m_tdata, m_tuser, m_tlast
  );

  modport slave (
    output ch_req, ch_valid, ch_data, ch_last, m_tready,
    input  can_forward, m_tvalid, m_tdata, m_tuser, m_tlast
  );

endinterface

// File: rtl/axi_stream_channel_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after the pointer, wrapping N-1 -> 0.
module rr_arbiter #(
  parameter int N  = 5,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] cand;

  // Scan from farthest to nearest so the nearest requester after the pointer is written last.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    cand    = '0;
    any_o   = |req_i;
    for (int k = N; k >= 1; k--) begin
      cand = IW'((int'(ptr_i) + k) % N);
      if (req_i[cand]) begin
        grant_o       = '0;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/axi_stream_channel_sched.sv
// Grants one AXI-channel converter at a time onto the shared stream, holds the grant to the last
// beat (or an idle timeout) and registers the beats tagged with the channel's stream type.
module axi_stream_channel_sched #(
  parameter int NUM_CH            = 5,
  parameter int DATA_WIDTH        = 128,
  parameter int STREAM_TYPE_WIDTH = 3,
  parameter int TIMEOUT           = 255
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        sched_enable,
  axi_stream_channel_sched_if.master  bus,
  output logic                        timeout_err
);

  import ethhelper_stream_pkg::*;

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  sched_state_t                 state_q, state_d;
  logic [NUM_CH-1:0]            gnt_q, gnt_d;
  logic [IW-1:0]                g_q, g_d;
  logic [IW-1:0]                ptr_q, ptr_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic                         tvalid_q, tvalid_d;
  logic [DATA_WIDTH-1:0]        tdata_q, tdata_d;
  logic [STREAM_TYPE_WIDTH-1:0] tuser_q, tuser_d;
  logic                         tlast_q, tlast_d;
  logic                         terr_q, terr_d;

  logic [NUM_CH-1:0] arb_grant;
  logic [IW-1:0]     arb_idx;
  logic              arb_any;
  logic              busy, out_free, g_valid, g_last, accept;

  rr_arbiter #(.N(NUM_CH), .IW(IW)) u_arb (
    .req_i   (bus.ch_req),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  assign busy     = (state_q == BUSY);
  assign out_free = !tvalid_q || bus.m_tready;
  assign g_valid  = |(gnt_q & bus.ch_valid);
  assign g_last   = |(gnt_q & bus.ch_last);
  assign accept   = busy && out_free && g_valid;

  assign bus.can_forward = (busy && out_free) ? gnt_q : '0;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    g_d      = g_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    tvalid_d = bus.m_tready ? 1'b0 : tvalid_q;
    tdata_d  = tdata_q;
    tuser_d  = tuser_q;
    tlast_d  = tlast_q;
    terr_d   = 1'b0;

    if (accept) begin
      tvalid_d = 1'b1;
      tdata_d  = bus.ch_data[g_q*DATA_WIDTH +: DATA_WIDTH];
      tuser_d  = STREAM_TYPE_WIDTH'(g_q);
      tlast_d  = g_last;
    end

    case (state_q)
      IDLE: begin
        if (sched_enable && arb_any) begin
          state_d = BUSY;
          gnt_d   = arb_grant;
          g_d     = arb_idx;
          ptr_d   = arb_idx;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        // Only cycles where the channel could have sent but did not count toward the timeout.
        if (accept) begin
          cnt_d = '0;
          if (g_last) state_d = IDLE;
        end else if (out_free && !g_valid) begin
          if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_d = IDLE;
            terr_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      g_q      <= '0;
      ptr_q    <= IW'(NUM_CH - 1);
      cnt_q    <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tuser_q  <= '0;
      tlast_q  <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      g_q      <= g_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tuser_q  <= tuser_d;
      tlast_q  <= tlast_d;
      terr_q   <= terr_d;
    end
  end

  assign bus.m_tvalid = tvalid_q;
  assign bus.m_tdata  = tdata_q;
  assign bus.m_tuser  = tuser_q;
  assign bus.m_tlast  = tlast_q;
  assign timeout_err  = terr_q;

endmodule

// File: tb/tb_axi_stream_channel_sched.sv
// Directed bench for the channel scheduler: expected beats are queued as the bench offers them
// and compared when they leave the output stream.
module tb_axi_stream_channel_sched;

  import ethhelper_stream_pkg::*;

  localparam int NCH = 5;
  localparam int DW  = 128;
  localparam int TW  = 3;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [TW-1:0] u;
    logic          l;
  } beat_t;

  logic clk = 1'b0;
  logic resetn;
  logic sched_enable;
  logic timeout_err;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    terr_cnt = 0;
  beat_t exp_q[$];

  axi_stream_channel_sched_if #(.NUM_CH(NCH), .DATA_WIDTH(DW), .STREAM_TYPE_WIDTH(TW)) bus ();

  axi_stream_channel_sched #(
    .NUM_CH(NCH), .DATA_WIDTH(DW), .STREAM_TYPE_WIDTH(TW), .TIMEOUT(4)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .sched_enable (sched_enable),
    .bus          (bus.master),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_beat(input int ch, input logic [DW-1:0] d, input logic l);
    bus.ch_data[ch*DW +: DW] = d;
    bus.ch_last[ch]          = l;
  endtask

  // Output monitor: a beat leaves on the next rising edge when valid and ready are both high here.
  always @(negedge clk) begin
    if (resetn && bus.m_tvalid && bus.m_tready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $error("FAIL out_unexpected: observed beat %0h tuser %0d, expected no beat", bus.m_tdata, bus.m_tuser);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("out_data", bus.m_tdata, e.d);
        chk("out_user", DW'(bus.m_tuser), DW'(e.u));
        chk("out_last", DW'(bus.m_tlast), DW'(e.l));
      end
    end
  end

  always @(negedge clk) if (timeout_err) terr_cnt++;

  // Converter model: present beats on channel ch, queue each one the cycle it is accepted.
  task automatic run_pkt(input int ch, input int nb, input logic [DW-1:0] base,
                         input int stall_beat, input int stall_len);
    int b = 0;
    int waitc = 0;
    bus.ch_req[ch]   = 1'b1;
    bus.ch_valid[ch] = 1'b1;
    set_beat(ch, base, nb == 1);
    while (b < nb && waitc < 20 * nb) begin
      @(negedge clk);
      waitc++;
      if (bus.can_forward != '0) chk("grant_onehot", DW'(bus.can_forward), DW'(1 << ch));
      if (bus.can_forward[ch]) begin
        exp_q.push_back('{d: base + DW'(b), u: TW'(ch), l: (b == nb - 1)});
        @(posedge clk); #1;
        b++;
        if (b < nb) set_beat(ch, base + DW'(b), b == nb - 1);
        if (b == stall_beat) begin
          bus.m_tready = 1'b0;
          for (int k = 0; k < stall_len; k++) begin
            @(negedge clk);
            chk("stall_cf", DW'(bus.can_forward), '0);
            chk("stall_tvalid", DW'(bus.m_tvalid), DW'(1));
            chk("stall_tdata", bus.m_tdata, base + DW'(b - 1));
            chk("stall_terr", DW'(timeout_err), '0);
            @(posedge clk); #1;
          end
          bus.m_tready = 1'b1;
        end
      end
    end
    bus.ch_req[ch]   = 1'b0;
    bus.ch_valid[ch] = 1'b0;
    bus.ch_last[ch]  = 1'b0;
    if (b < nb) chk("pkt_complete", DW'(b), DW'(nb));
  endtask

  initial begin
    int order[6] = '{0, 1, 2, 3, 4, 0};
    int gcount;
    int cycles;
    logic prev_nz;
    logic [DW-1:0] base_v;

    resetn       = 1'b0;
    sched_enable = 1'b1;
    bus.ch_req   = '0;
    bus.ch_valid = '0;
    bus.ch_last  = '0;
    bus.ch_data  = '0;
    bus.m_tready = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_cf", DW'(bus.can_forward), '0);
    chk("rst_tvalid", DW'(bus.m_tvalid), '0);
    chk("rst_tdata", bus.m_tdata, '0);
    chk("rst_tuser", DW'(bus.m_tuser), '0);
    chk("rst_tlast", DW'(bus.m_tlast), '0);
    chk("rst_terr", DW'(timeout_err), '0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // 1: single-beat ch0 packet, registered grant and 1-cycle output latency
    @(posedge clk); #1;
    bus.ch_req[CH_AW]   = 1'b1;
    bus.ch_valid[CH_AW] = 1'b1;
    set_beat(CH_AW, DW'('hA5), 1'b1);
    @(negedge clk);
    chk("t1_cf_before", DW'(bus.can_forward), '0);
    @(negedge clk);
    chk("t1_cf_grant", DW'(bus.can_forward), DW'(5'b00001));
    exp_q.push_back('{d: DW'('hA5), u: TW'(CH_AW), l: 1'b1});
    @(posedge clk); #1;
    bus.ch_req[CH_AW]   = 1'b0;
    bus.ch_valid[CH_AW] = 1'b0;
    @(negedge clk);
    chk("t1_tvalid", DW'(bus.m_tvalid), DW'(1));
    chk("t1_tdata", bus.m_tdata, DW'('hA5));
    chk("t1_tlast", DW'(bus.m_tlast), DW'(1));
    chk("t1_cf_after", DW'(bus.can_forward), '0);
    @(negedge clk);
    chk("t1_tvalid_clear", DW'(bus.m_tvalid), '0);

    // 2: two-beat R packet
    run_pkt(CH_R, 2, DW'('h11), 0, 0);
    repeat (3) @(negedge clk);

    // 3: all channels requesting, one beat each, round-robin with an idle gap
    @(posedge clk); #1;
    for (int i = 0; i < NCH; i++) set_beat(i, DW'('hC0 + i), 1'b1);
    bus.ch_req   = '1;
    bus.ch_valid = '1;
    gcount  = 0;
    cycles  = 0;
    prev_nz = 1'b0;
    while (gcount < 6 && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (bus.can_forward != '0) begin
        chk("rr_order", DW'(bus.can_forward), DW'(1 << order[gcount]));
        chk("rr_gap", DW'(prev_nz), '0);
        exp_q.push_back('{d: DW'('hC0 + order[gcount]), u: TW'(order[gcount]), l: 1'b1});
        gcount++;
      end
      prev_nz = (bus.can_forward != '0);
    end
    chk("rr_count", DW'(gcount), DW'(6));
    @(posedge clk); #1;
    bus.ch_req   = '0;
    bus.ch_valid = '0;
    bus.ch_last  = '0;
    repeat (3) @(negedge clk);

    // 4: backpressure for 5 cycles in a 3-beat ch1 packet, longer than the timeout
    @(posedge clk); #1;
    run_pkt(CH_W, 3, DW'('h31), 1, 5);
    repeat (3) @(negedge clk);
    chk("t4_no_timeout", DW'(terr_cnt), '0);

    // 5: timeout on a granted channel that never sends; request drop does not revoke
    @(posedge clk); #1;
    bus.ch_req[CH_B] = 1'b1;
    @(negedge clk);
    chk("t5_cf_idle", DW'(bus.can_forward), '0);
    @(posedge clk); #1;
    bus.ch_req[CH_B] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t5_cf_held", DW'(bus.can_forward), DW'(5'b00100));
      chk("t5_terr_low", DW'(timeout_err), '0);
    end
    @(negedge clk);
    chk("t5_terr_pulse", DW'(timeout_err), DW'(1));
    chk("t5_cf_revoked", DW'(bus.can_forward), '0);
    @(negedge clk);
    chk("t5_terr_one_cycle", DW'(timeout_err), '0);
    chk("t5_terr_count", DW'(terr_cnt), DW'(1));
    bus.ch_req[CH_B] = 1'b1;
    run_pkt(CH_AR, 1, DW'('h5A), 0, 0);
    bus.ch_req[CH_B] = 1'b0;
    repeat (3) @(negedge clk);

    // 6: asynchronous reset between R beats with a held output beat
    @(posedge clk); #1;
    bus.m_tready = 1'b0;
    bus.ch_req[CH_R]   = 1'b1;
    bus.ch_valid[CH_R] = 1'b1;
    set_beat(CH_R, DW'('h61), 1'b0);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!bus.can_forward[CH_R] && cycles < 10);
    chk("t6_grant", DW'(bus.can_forward), DW'(5'b10000));
    @(posedge clk); #1;
    set_beat(CH_R, DW'('h62), 1'b1);
    @(negedge clk);
    chk("t6_held_tvalid", DW'(bus.m_tvalid), DW'(1));
    chk("t6_held_tdata", bus.m_tdata, DW'('h61));
    #2 resetn = 1'b0;
    #1;
    chk("t6_rst_tvalid", DW'(bus.m_tvalid), '0);
    chk("t6_rst_tdata", bus.m_tdata, '0);
    chk("t6_rst_tuser", DW'(bus.m_tuser), '0);
    chk("t6_rst_tlast", DW'(bus.m_tlast), '0);
    chk("t6_rst_cf", DW'(bus.can_forward), '0);
    bus.ch_valid[CH_R] = 1'b0;
    bus.ch_last[CH_R]  = 1'b0;
    bus.m_tready = 1'b1;
    sched_enable = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6_disabled_cf", DW'(bus.can_forward), '0);
    end
    sched_enable = 1'b1;
    base_v = DW'('h77);
    run_pkt(CH_AW, 1, base_v, 0, 0);
    bus.ch_req[CH_R] = 1'b0;
    repeat (4) @(negedge clk);

    chk("scoreboard_drained", DW'(exp_q.size()), '0);
    chk("final_terr_count", DW'(terr_cnt), DW'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
